multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing control unit for the multicycle RV32I datapath. Decodes the instruction register fields, steps a Moore state machine through fetch/decode/execute/writeback, and drives the datapath enables, mux selects and the 4-bit ALUControl code consumed by the ALU. It also consumes the ALU's Zero flag to resolve branches.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  IR/OldPC enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A reg, 11=zero
- ALUSrcB  out  2  00=B reg, 01=ImmExt, 10=constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  4  0000 AND, 0001 OR, 0010 ADD, 0100 XOR, 0110 SUB, 0111 SLT, 1000 SLTU, 1010 SLL, 1011 SRL, 1100 SRA
- IllegalOp  out  1  undecodable instruction flag

## Operation
- Moore FSM; every output is a function of state and the IR fields. Defaults: enables 0, selects 00, ALUControl=0010.
- FETCH: IRWrite, PCWrite, AdrSrc=0, SrcA=00, SrcB=10, ADD, ResultSrc=10 -> DECODE.
- DECODE: SrcA=01, SrcB=01, ADD (branch/jal target into ALUOut). Next by op: 0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1100011 BRANCH; 1101111 JAL; 0110111 LUI; other -> illegal handling.
- MEMADR: SrcA=10, SrcB=01, ADD -> MEMREAD (op 0000011) else MEMWRITE.
- MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite -> FETCH.
- EXECR: SrcA=10, SrcB=00; EXECI: SrcA=10, SrcB=01; both -> ALUWB with decoded ALUControl.
- LUI: SrcA=11, SrcB=01, ADD -> ALUWB.
- JAL: SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite -> FETCH.
- BRANCH: SrcA=10, SrcB=00, ResultSrc=00; beq/bne SUB, blt/bge SLT, bltu/bgeu SLTU; PCWrite = taken; taken = Zero for beq/bge/bgeu, !Zero for bne/blt/bltu -> FETCH. funct3 010/011 illegal.
- ALU decode (R and I): 000 ADD (SUB only for R with funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 funct7b5 ? SRA : SRL, 110 OR, 111 AND.
- ImmSrc decoded from op in every state: lw/I-ALU I, sw S, branch B, jal J, lui U, else 000.

## Timing
- rst_n low: state=FETCH immediately; all enables (PCWrite, IRWrite, MemWrite, RegWrite) forced 0, selects 00, ALUControl 0010, IllegalOp 0. First FETCH executes on the first rising edge with rst_n high.
- Cycles per instruction: lw 5; sw, R, I, jal, lui 4; branch 3 (taken or not).
- Zero sampled combinationally in BRANCH only; must settle before the clock edge ending BRANCH.
- rst_n assertion mid-instruction aborts it; no write enable is asserted during reset.
- IR fields are held stable by the datapath from DECODE to the end of the instruction.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: illegal op or branch funct3 -> ERROR state; all enables 0, IllegalOp=1, held until rst_n.
- Undefined: illegal instructions behave as a NOP (DECODE/BRANCH -> FETCH, no writes); IllegalOp tied 0.

## Test plan
- Reset release, IR=addi x1,x0,5 -> FETCH,DECODE,EXECI,ALUWB; ALUControl=0010, SrcB=01; RegWrite only in cycle 4.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=0110 in EXECR; sra (101,1) -> 1100; srl (101,0) -> 1011.
- lw then sw -> 5 and 4 cycles; AdrSrc=1 in MEMREAD/MEMWRITE; MemWrite one cycle; ResultSrc=01 with RegWrite in MEMWB.
- bne with Zero=0 -> PCWrite=1 in BRANCH; with Zero=1 -> PCWrite=0; bgeu -> ALUControl=1000, taken when Zero=1.
- IR op=1111111 -> with MC_ILLEGAL_TRAP_EN, IllegalOp=1 and no enables until reset; without, returns to FETCH after DECODE with no writes.
- rst_n pulsed low in MEMWRITE -> MemWrite drops asynchronously; restart in FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR fields and ALU Zero flag into the control unit,
// datapath enables, mux selects and ALU operation code out of it.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       IllegalOp;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalOp
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencing FSM for the multicycle RV32I datapath.
// Define MC_ILLEGAL_TRAP_EN to trap undecodable instructions in a sticky ERROR state.
module multicycle_controller (
    input logic clk,
    input logic rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, LUI, JAL, ALUWB, BRANCH
`ifdef MC_ILLEGAL_TRAP_EN
        , ERROR
`endif
    } state_t;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = ERROR;
`else
    localparam state_t ILL_NEXT = FETCH;
`endif

    state_t state, next;
    logic [3:0] alu_dec;
    logic [3:0] br_alu;
    logic [2:0] imm_dec;
    logic       br_ok;
    logic       taken;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= FETCH;
        else state <= next;

    always_comb begin
        case (bus.funct3)
            3'b000:  alu_dec = (bus.op == OP_R && bus.funct7b5) ? 4'b0110 : 4'b0010;
            3'b001:  alu_dec = 4'b1010;
            3'b010:  alu_dec = 4'b0111;
            3'b011:  alu_dec = 4'b1000;
            3'b100:  alu_dec = 4'b0100;
            3'b101:  alu_dec = bus.funct7b5 ? 4'b1100 : 4'b1011;
            3'b110:  alu_dec = 4'b0001;
            default: alu_dec = 4'b0000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   imm_dec = 3'b001;
            OP_BR:   imm_dec = 3'b010;
            OP_JAL:  imm_dec = 3'b011;
            OP_LUI:  imm_dec = 3'b100;
            default: imm_dec = 3'b000;
        endcase
    end

    // beq/bne compare by SUB, the others by SLT/SLTU; funct3[0]^funct3[2] flips the Zero sense
    assign br_alu = bus.funct3[2] ? (bus.funct3[1] ? 4'b1000 : 4'b0111) : 4'b0110;
    assign br_ok  = bus.funct3[2:1] != 2'b01;
    assign taken  = bus.Zero ^ (bus.funct3[0] ^ bus.funct3[2]);

    always_comb begin
        next           = FETCH;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 4'b0010;
        bus.IllegalOp  = 1'b0;
        bus.ImmSrc     = rst_n ? imm_dec : 3'b000;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    bus.IRWrite   = 1'b1;
                    bus.PCWrite   = 1'b1;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    next          = DECODE;
                end
                DECODE: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                    next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                           bus.op == OP_R   ? EXECR  :
                           bus.op == OP_I   ? EXECI  :
                           bus.op == OP_BR  ? BRANCH :
                           bus.op == OP_JAL ? JAL    :
                           bus.op == OP_LUI ? LUI    : ILL_NEXT;
                end
                MEMADR: begin
                    bus.ALUSrcA = 2'b10;
                    bus.ALUSrcB = 2'b01;
                    next        = bus.op == OP_LW ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    bus.AdrSrc = 1'b1;
                    next       = MEMWB;
                end
                MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                EXECR: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = alu_dec;
                    next           = ALUWB;
                end
                EXECI: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUSrcB    = 2'b01;
                    bus.ALUControl = alu_dec;
                    next           = ALUWB;
                end
                LUI: begin
                    bus.ALUSrcA = 2'b11;
                    bus.ALUSrcB = 2'b01;
                    next        = ALUWB;
                end
                // Link value OldPC+4 is computed here while PC takes the target held in ALUOut
                JAL: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                    bus.PCWrite = 1'b1;
                    next        = ALUWB;
                end
                ALUWB: bus.RegWrite = 1'b1;
                BRANCH: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = br_alu;
                    bus.PCWrite    = br_ok & taken;
                    next           = br_ok ? FETCH : ILL_NEXT;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                ERROR: begin
                    bus.IllegalOp = 1'b1;
                    next          = ERROR;
                end
`endif
                default: next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench; per-cycle expected control words are
// queued when an instruction is presented and compared cycle by cycle.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111, SLTU = 4'b1000;

    typedef struct {
        string       tag;
        logic [18:0] w;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    exp_t q[$];

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] cw(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                       logic [1:0] res, logic [1:0] sa, logic [1:0] sb,
                                       logic [3:0] alu, logic [2:0] imm, logic ill);
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [18:0] got_word();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.IllegalOp};
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] op);
        case (op)
            OP_SW:   return 3'b001;
            OP_BR:   return 3'b010;
            OP_JAL:  return 3'b011;
            OP_LUI:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic is_r, logic [2:0] f3, logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? SUB : ADD;
            3'd1:    return 4'b1010;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return 4'b0100;
            3'd5:    return f7 ? 4'b1100 : 4'b1011;
            3'd6:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(string tag, logic [18:0] got, logic [18:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic push(string tag, logic [18:0] w);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        #1;
        e = q.pop_front();
        check(e.tag, got_word(), e.w);
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic issue(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
        logic [2:0] imm;
        logic [3:0] balu;
        logic       tk;
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.Zero = z;
        imm = imm_of(op);
        push({name, ".fetch"}, cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, ADD, imm, 0));
        push({name, ".decode"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD, imm, 0));
        case (op)
            OP_LW: begin
                push({name, ".memadr"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, imm, 0));
                push({name, ".memread"}, cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, imm, 0));
                push({name, ".memwb"}, cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ADD, imm, 0));
            end
            OP_SW: begin
                push({name, ".memadr"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD, imm, 0));
                push({name, ".memwrite"}, cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, ADD, imm, 0));
            end
            OP_R, OP_I, OP_LUI, OP_JAL: begin
                if (op == OP_R)
                    push({name, ".execr"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(1, f3, f7), imm, 0));
                else if (op == OP_I)
                    push({name, ".execi"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(0, f3, f7), imm, 0));
                else if (op == OP_LUI)
                    push({name, ".lui"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, ADD, imm, 0));
                else
                    push({name, ".jal"}, cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD, imm, 0));
                push({name, ".aluwb"}, cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD, imm, 0));
            end
            OP_BR: begin
                case (f3)
                    3'b000:  begin balu = SUB;  tk = z;  end
                    3'b001:  begin balu = SUB;  tk = !z; end
                    3'b100:  begin balu = SLT;  tk = !z; end
                    3'b101:  begin balu = SLT;  tk = z;  end
                    3'b110:  begin balu = SLTU; tk = !z; end
                    default: begin balu = SLTU; tk = z;  end
                endcase
                push({name, ".branch"}, cw(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, balu, imm, 0));
            end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++)
                    push({name, ".error"}, cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, imm, 1));
`endif
            end
        endcase
    endtask

    task automatic run(string name, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
        issue(name, op, f3, f7, z);
        drain();
    endtask

    initial begin
        bus.op = OP_I;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        #2;
        check("reset.async", got_word(), cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 0));
        @(posedge clk);
        #1;
        check("reset.held", got_word(), cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run("addi", OP_I, 3'b000, 1'b0, 1'b0);
        run("sub", OP_R, 3'b000, 1'b1, 1'b0);
        run("add", OP_R, 3'b000, 1'b0, 1'b0);
        run("sra", OP_R, 3'b101, 1'b1, 1'b0);
        run("srl", OP_R, 3'b101, 1'b0, 1'b0);
        run("slt", OP_R, 3'b010, 1'b0, 1'b0);
        run("srai", OP_I, 3'b101, 1'b1, 1'b0);
        run("xori", OP_I, 3'b100, 1'b0, 1'b0);
        run("andi", OP_I, 3'b111, 1'b0, 1'b0);
        run("lw", OP_LW, 3'b010, 1'b0, 1'b0);
        run("sw", OP_SW, 3'b010, 1'b0, 1'b0);
        run("bne_z0", OP_BR, 3'b001, 1'b0, 1'b0);
        run("bne_z1", OP_BR, 3'b001, 1'b0, 1'b1);
        run("beq_z1", OP_BR, 3'b000, 1'b0, 1'b1);
        run("blt_z0", OP_BR, 3'b100, 1'b0, 1'b0);
        run("bgeu_z1", OP_BR, 3'b111, 1'b0, 1'b1);
        run("bgeu_z0", OP_BR, 3'b111, 1'b0, 1'b0);
        run("jal", OP_JAL, 3'b000, 1'b0, 1'b0);
        run("lui", OP_LUI, 3'b000, 1'b0, 1'b0);
        // Abort a store in MEMWRITE with an asynchronous reset pulse
        issue("sw_rst", OP_SW, 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
        end
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("sw_rst.async", got_word(), cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 0));
        @(posedge clk);
        #1;
        check("sw_rst.held", got_word(), cw(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 0));
        @(negedge clk);
        rst_n = 1'b1;
        run("addi_after_rst", OP_I, 3'b000, 1'b0, 1'b0);
        run("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        run("addi_after_ill", OP_I, 3'b000, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
